// File: rtl/sr_bank_writer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sr_bank_writer_pkg
//  Purpose  : Shared FSM encoding, S/R excitation constants and defaults.
//  Revision : 1.0 - initial release
// ============================================================================
package sr_bank_writer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_SETTLE = 2'd2,
        ST_CHECK  = 2'd3
    } state_t;

    // Excitation encoded as {S, R}; the illegal 2'b11 has no constant.
    localparam logic [1:0] c_exc_set  = 2'b10;
    localparam logic [1:0] c_exc_rst  = 2'b01;
    localparam logic [1:0] c_exc_hold = 2'b00;

    localparam int c_settle_cyc_dflt = 2;
    localparam int c_max_retry_dflt  = 3;

    function automatic logic [1:0] sr_excite_bit(input logic q, input logic t);
        if (!q && t)
            return c_exc_set;
        else if (q && !t)
            return c_exc_rst;
        return c_exc_hold;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sr_bank_writer_excite.sv
`default_nettype none
// ============================================================================
//  Module   : sr_excite
//  Purpose  : Combinational per-bit SR excitation, current q versus target t.
//  Revision : 1.0 - initial release
// ============================================================================
module sr_excite
    import sr_bank_writer_pkg::*;
#(
    parameter int W = 4
) (
    input  logic [W-1:0] q,
    input  logic [W-1:0] t,
    output logic [W-1:0] s,
    output logic [W-1:0] r
);

    for (genvar i = 0; i < W; i++) begin : g_bit
        logic [1:0] w_sr;
        assign w_sr = sr_excite_bit(q[i], t[i]);
        assign s[i] = w_sr[1];
        assign r[i] = w_sr[0];
    end

endmodule
`default_nettype wire

// File: rtl/sr_bank_writer.sv
`default_nettype none
// ============================================================================
//  Module   : sr_bank_writer
//  Purpose  : Drives an external SR flip-flop bank to a target word with
//             settle, read-back verification and bounded retries.
//  Revision : 1.0 - initial release
// ============================================================================
module sr_bank_writer
    import sr_bank_writer_pkg::*;
#(
    parameter int W          = 4,
    parameter int SETTLE_CYC = c_settle_cyc_dflt,
    parameter int MAX_RETRY  = c_max_retry_dflt
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] target,
    input  logic [W-1:0] q_in,
    output logic [W-1:0] s_out,
    output logic [W-1:0] r_out,
    output logic         busy,
    output logic         done,
    output logic         error,
    output logic [3:0]   retries
);

    localparam int              c_cnt_w       = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [c_cnt_w-1:0] c_settle_load = c_cnt_w'(SETTLE_CYC - 1);
    localparam logic [3:0]      c_max_retry   = 4'(MAX_RETRY);

    state_t             r_state, w_state_nxt;
    logic [W-1:0]       r_target, w_target_nxt;
    logic [W-1:0]       r_s, w_s_nxt;
    logic [W-1:0]       r_r, w_r_nxt;
    logic               r_busy, w_busy_nxt;
    logic               r_done, w_done_nxt;
    logic               r_error, w_error_nxt;
    logic [3:0]         r_retries, w_retries_nxt;
    logic [c_cnt_w-1:0] r_cnt, w_cnt_nxt;

    logic [W-1:0]       w_exc_t;
    logic [W-1:0]       w_exc_s;
    logic [W-1:0]       w_exc_r;

    // In IDLE the excitation must see the target arriving on this very edge.
    assign w_exc_t = (r_state == ST_IDLE) ? target : r_target;

    sr_excite #(.W(W)) u_excite (
        .q (q_in),
        .t (w_exc_t),
        .s (w_exc_s),
        .r (w_exc_r)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_target  <= '0;
            r_s       <= '0;
            r_r       <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_error   <= 1'b0;
            r_retries <= '0;
            r_cnt     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_target  <= w_target_nxt;
            r_s       <= w_s_nxt;
            r_r       <= w_r_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            r_error   <= w_error_nxt;
            r_retries <= w_retries_nxt;
            r_cnt     <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_target_nxt  = r_target;
        w_s_nxt       = '0;
        w_r_nxt       = '0;
        w_busy_nxt    = r_busy;
        w_done_nxt    = 1'b0;
        w_error_nxt   = 1'b0;
        w_retries_nxt = r_retries;
        w_cnt_nxt     = r_cnt;

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt   = ST_DRIVE;
                    w_target_nxt  = target;
                    w_retries_nxt = '0;
                    w_s_nxt       = w_exc_s;
                    w_r_nxt       = w_exc_r;
                    w_busy_nxt    = 1'b1;
                end
            end
            ST_DRIVE: begin
                w_cnt_nxt   = c_settle_load;
                w_state_nxt = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (r_cnt == '0)
                    w_state_nxt = ST_CHECK;
                else
                    w_cnt_nxt = r_cnt - 1'b1;
            end
            ST_CHECK: begin
                // Case inequality so an X read-back counts as a mismatch.
                if (q_in !== r_target) begin
                    if (r_retries < c_max_retry) begin
                        w_retries_nxt = r_retries + 4'd1;
                        w_s_nxt       = w_exc_s;
                        w_r_nxt       = w_exc_r;
                        w_state_nxt   = ST_DRIVE;
                    end else begin
                        w_error_nxt = 1'b1;
                        w_busy_nxt  = 1'b0;
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_done_nxt  = 1'b1;
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    assign s_out   = r_s;
    assign r_out   = r_r;
    assign busy    = r_busy;
    assign done    = r_done;
    assign error   = r_error;
    assign retries = r_retries;

endmodule
`default_nettype wire
